crc_unfold2_feeder: RTL and testbench

Upstream framing stage for the 2-bit-per-clock unfolded CRC-5 LFSR. Accepts one parallel message word per valid/ready handshake, builds the CRC frame with leading zero pad and optional zero augmentation, and serializes it MSB-first as 2-bit symbols, one per accepted clock. Marks the first symbol so the LFSR clears its register and the last symbol so the LFSR latches its remainder onto `data_out`.

---
 rtl/crc_pkg.sv | 19 +
 rtl/crc_sym_shreg.sv | 37 +++
 rtl/crc_unfold2_feeder.sv | 108 ++++++++++
 tb/tb_crc_unfold2_feeder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC-5 unfolded-LFSR datapath: widths, generator,
// symbol-count helper and feeder FSM states.
package crc_pkg;

    localparam int CRC_W = 5;
    localparam int SYM_W = 2;
    // x^5 + x^2 + 1, implicit leading term dropped
    localparam logic [CRC_W-1:0] CRC5_POLY = 5'b00101;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } feed_state_t;

    function automatic int crc_nsym(input int msg_w, input int aug);
        return (msg_w + aug + SYM_W - 1) / SYM_W;
    endfunction

endpackage

// File: rtl/crc_sym_shreg.sv
// Loadable frame shift register; presents the top symbol and shifts left by one
// symbol per enabled cycle, holding otherwise.
module crc_sym_shreg #(
    parameter int FRAME_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [FRAME_W-1:0] frame_i,
    output logic [1:0]         sym_o
);
    import crc_pkg::*;

    logic [FRAME_W-1:0] shreg_q;
    logic [FRAME_W-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = frame_i;
        end else if (shift_i) begin
            shreg_d = shreg_q << SYM_W;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign sym_o = shreg_q[FRAME_W-1 -: 2];

endmodule

// File: rtl/crc_unfold2_feeder.sv
// Frames a message word (zero pad + optional CRC_W zero augmentation when
// CRC_FEED_AUG_EN is defined) and streams it MSB-first as 2-bit symbols.
module crc_unfold2_feeder #(
    parameter int MSG_W = 6,
    parameter int CRC_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [MSG_W-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       sym_out,
    output logic             sym_valid,
    output logic             sym_first,
    output logic             sym_last,
    input  logic             sym_ready,
    output logic             busy
);
    import crc_pkg::*;

`ifdef CRC_FEED_AUG_EN
    localparam int AUG = CRC_W;
`else
    localparam int AUG = 0;
`endif
    localparam int NSYM    = crc_nsym(MSG_W, AUG);
    localparam int FRAME_W = 2 * NSYM;
    localparam int CNT_W   = (NSYM > 1) ? $clog2(NSYM) : 1;

    feed_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               first_q, first_d;
    logic               load, shift, last;
    logic [FRAME_W-1:0] frame;

    // Leading pad comes for free from zero-extension; augmentation from the shift.
    assign frame = FRAME_W'(data_in) << AUG;

    assign last     = (state_q == SHIFT) && (cnt_q == '0);
    assign in_ready = !reset && ((state_q == IDLE) || (last && sym_ready));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = CNT_W'(NSYM - 1);
                    first_d = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sym_ready) begin
                    if (cnt_q == '0) begin
                        if (in_valid) begin
                            load    = 1'b1;
                            cnt_d   = CNT_W'(NSYM - 1);
                            first_d = 1'b1;
                        end else begin
                            shift   = 1'b1;
                            first_d = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        shift   = 1'b1;
                        cnt_d   = cnt_q - 1'b1;
                        first_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    crc_sym_shreg #(
        .FRAME_W (FRAME_W)
    ) u_shreg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .frame_i (frame),
        .sym_o   (sym_out)
    );

    assign sym_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign sym_first = first_q;
    assign sym_last  = last;

endmodule

// File: tb/tb_crc_unfold2_feeder.sv
// Directed bench for crc_unfold2_feeder with a symbol/CRC scoreboard; follows
// CRC_FEED_AUG_EN the same way the design does.
module tb_crc_unfold2_feeder;
    localparam int MSG_W = 6;
    localparam int CRC_W = 5;
`ifdef CRC_FEED_AUG_EN
    localparam int AUG = CRC_W;
`else
    localparam int AUG = 0;
`endif
    localparam int NS = (MSG_W + AUG + 1) / 2;
    localparam int FW = 2 * NS;

    logic             clk;
    logic             reset;
    logic [MSG_W-1:0] data_in;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sym_out;
    logic             sym_valid;
    logic             sym_first;
    logic             sym_last;
    logic             sym_ready;
    logic             busy;

    crc_unfold2_feeder #(.MSG_W(MSG_W), .CRC_W(CRC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .sym_first (sym_first),
        .sym_last  (sym_last),
        .sym_ready (sym_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] s;
        logic       f;
        logic       l;
    } exp_t;

    exp_t       sq[$];
    logic [4:0] gq[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic [4:0] lr     = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Golden CRC: remainder of msg * x^5 divided by x^5 + x^2 + 1.
    function automatic logic [4:0] gold(input logic [MSG_W-1:0] m);
        logic [MSG_W+4:0] v;
        v = {m, 5'b00000};
        for (int i = MSG_W + 4; i >= 5; i--) begin
            if (v[i]) v[i -: 6] = v[i -: 6] ^ 6'b100101;
        end
        return v[4:0];
    endfunction

    function automatic logic [4:0] lfsr_step(input logic [4:0] r, input logic b);
        logic [4:0] n;
`ifdef CRC_FEED_AUG_EN
        n = {r[3:0], b};
        if (r[4]) n = n ^ 5'b00101;
`else
        n = {r[3:0], 1'b0};
        if (b ^ r[4]) n = n ^ 5'b00101;
`endif
        return n;
    endfunction

    function automatic logic fbit(input logic [MSG_W-1:0] w, input int j);
        int pad;
        pad = FW - MSG_W - AUG;
        if (j < pad) return 1'b0;
        if (j < pad + MSG_W) return w[MSG_W-1-(j-pad)];
        return 1'b0;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (sym_valid && sym_ready && !reset) begin
            if (sq.size() == 0) begin
                chk("sym_unexpected", 32'd1, 32'd0);
            end else begin
                e = sq.pop_front();
                chk("sym_out", sym_out, e.s);
                chk("sym_first", sym_first, e.f);
                chk("sym_last", sym_last, e.l);
                if (sym_first) lr = '0;
                lr = lfsr_step(lfsr_step(lr, sym_out[1]), sym_out[0]);
                if (sym_last) begin
                    if (gq.size() == 0) chk("crc_missing", 32'd1, 32'd0);
                    else chk("crc_rem", lr, gq.pop_front());
                end
            end
        end
    end

    task automatic send_word(input logic [MSG_W-1:0] w);
        int t;
        exp_t e;
        data_in  = w;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        for (int i = 0; i < NS; i++) begin
            e.s = {fbit(w, 2*i), fbit(w, 2*i+1)};
            e.f = (i == 0);
            e.l = (i == NS - 1);
            sq.push_back(e);
        end
        gq.push_back(gold(w));
        #1;
    endtask

    task automatic drain(input bit rnd);
        int t;
        t = 0;
        while (sq.size() != 0 && t < 400) begin
            if (rnd) sym_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            t++;
        end
        sym_ready = 1'b1;
        chk("drain_done", sq.size(), 32'd0);
    endtask

    initial begin
        int t0;
        int idx;
        reset     = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        sym_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sym_valid", sym_valid, 32'd0);
        chk("rst_sym_out", sym_out, 32'd0);
        chk("rst_sym_first", sym_first, 32'd0);
        chk("rst_sym_last", sym_last, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_in_ready", in_ready, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 32'd1);

        // single frame, ready held high
        send_word(6'b111111);
        in_valid = 1'b0;
        for (int i = 0; i < NS; i++) begin
            chk("t1_in_ready", in_ready, (i == NS - 1));
            chk("t1_busy", busy, 32'd1);
            @(posedge clk); #1;
        end
        chk("t1_idle_busy", busy, 32'd0);
        chk("t1_idle_valid", sym_valid, 32'd0);
        chk("t1_idle_in_ready", in_ready, 32'd1);
        chk("t1_queue", sq.size(), 32'd0);

        // back-to-back frames
        send_word(6'b101011);
        t0 = cyc;
        send_word(6'b111111);
        in_valid = 1'b0;
        drain(1'b0);
        chk("b2b_cycles", cyc - t0, 2 * NS);
        chk("b2b_busy", busy, 32'd0);

        // downstream stall after the second symbol
        send_word(6'b111111);
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        sym_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_sym_out", sym_out, sq[0].s);
            chk("stall_sym_first", sym_first, sq[0].f);
            chk("stall_sym_last", sym_last, sq[0].l);
            chk("stall_busy", busy, 32'd1);
            chk("stall_valid", sym_valid, 32'd1);
        end
        sym_ready = 1'b1;
        drain(1'b0);

        // reset in the middle of a frame
        send_word(6'b111111);
        in_valid = 1'b0;
        idx = (NS >= 4) ? 4 : NS;
        repeat (idx - 1) begin
            @(posedge clk); #1;
        end
        reset     = 1'b1;
        sym_ready = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 32'd0);
        @(posedge clk); #1;
        chk("midrst_sym_out", sym_out, 32'd0);
        chk("midrst_sym_valid", sym_valid, 32'd0);
        chk("midrst_sym_first", sym_first, 32'd0);
        chk("midrst_sym_last", sym_last, 32'd0);
        chk("midrst_busy", busy, 32'd0);
        sq.delete();
        gq.delete();
        reset     = 1'b0;
        sym_ready = 1'b1;
        #1;
        chk("midrst_in_ready_back", in_ready, 32'd1);
        send_word(6'b101011);
        in_valid = 1'b0;
        drain(1'b0);

        // random words under random backpressure
        for (int k = 0; k < 4; k++) begin
            send_word(MSG_W'($urandom_range(0, 63)));
            in_valid = 1'b0;
            drain(1'b1);
        end

        chk("final_busy", busy, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
